// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit-side blocks: byte width and arbiter FSM encoding.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating-priority search: first set bit of i_valid at or above i_ptr, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int w_j;
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      w_j     = (int'(i_ptr) + i) % N;
      o_found = o_found | i_valid[IW'(w_j)];
      o_idx   = i_valid[IW'(w_j)] ? IW'(w_j) : o_idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with packet locking and a busy-rise timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [BYTE_W-1:0]          tx_data,
  output logic                       tx_wr_en,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       lock,
  output logic                       timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [CW-1:0]      TO_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);

  logic [1:0]         r_state;
  logic [GW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_cnt;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [BYTE_W-1:0]  r_tx_data;
  logic               r_tx_wr_en;
  logic [GW-1:0]      r_grant_id;
  logic               r_lock;
  logic               r_timeout_err;

  logic [BYTE_W-1:0]  w_bytes [NUM_REQ];
  logic [NUM_REQ-1:0] w_elig;
  logic               w_found;
  logic [GW-1:0]      w_idx;
  logic [GW-1:0]      w_next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  // While a packet is open only its owner may be picked.
  assign w_elig     = r_lock ? (req_valid & (ONE << r_grant_id)) : req_valid;
  assign w_next_ptr = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + GW'(1);

  rr_picker #(.N(NUM_REQ), .IW(GW)) u_picker (
    .i_valid (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Arbiter FSM: accept, strobe, then follow tx_busy through the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_cnt         <= '0;
      r_req_ready   <= '0;
      r_tx_data     <= 8'h00;
      r_tx_wr_en    <= 1'b0;
      r_grant_id    <= '0;
      r_lock        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_req_ready   <= '0;
      r_tx_wr_en    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!tx_busy && w_found) begin
            r_req_ready <= ONE << w_idx;
            r_tx_data   <= w_bytes[w_idx];
            r_grant_id  <= w_idx;
            r_lock      <= ~req_last[w_idx];
            if (req_last[w_idx]) r_rr_ptr <= w_next_ptr;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_tx_wr_en <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            r_state <= S_WAIT_LO;
          end else if (r_cnt == TO_LAST) begin
            // Byte is dropped; the packet is abandoned so the grant is released.
            r_timeout_err <= 1'b1;
            r_lock        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_data     = r_tx_data;
  assign tx_wr_en    = r_tx_wr_en;
  assign grant_id    = r_grant_id;
  assign lock        = r_lock;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter busy model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 15;
  localparam int FRAME        = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        lock;
  logic        timeout_err;

  logic        model_en = 1'b1;
  logic        ext_busy = 1'b0;
  int          busy_cnt = 0;
  logic        overlap  = 1'b0;
  logic [7:0]  rx_byte  = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_wr_en(tx_wr_en), .tx_busy(tx_busy), .grant_id(grant_id),
    .lock(lock), .timeout_err(timeout_err)
  );

  assign tx_busy = ext_busy | (busy_cnt != 0);

  // Transmitter model: a strobe starts a FRAME-cycle busy window and latches the byte.
  always @(posedge clk) begin
    if (tx_wr_en && tx_busy) overlap <= 1'b1;
    if (tx_wr_en && model_en) begin
      busy_cnt <= FRAME;
      rx_byte  <= tx_data;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [7:0] d, input logic last, input logic v);
    req_data[8*i +: 8] = d;
    req_last[i]        = last;
    req_valid[i]       = v;
  endtask

  task automatic wait_ready(input int budget, output int k, output bit ok);
    ok = 1'b0;
    k  = -1;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) begin k = i; ok = 1'b1; end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (!tx_busy) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL idle_wait: tx_busy still %b after 200 cycles, want 0", tx_busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || tx_wr_en !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: ready=%b wr_en=%b to=%b, want 0000/0/0", req_ready, tx_wr_en, timeout_err);
    end
    checks++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: data=%h grant=%0d lock=%b, want 00/0/0", tx_data, grant_id, lock);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int k; bit ok;
    set_req(0, 8'hA5, 1'b1, 1'b1);
    wait_ready(50, k, ok);
    checks++;
    if (!ok || req_ready !== 4'b0001 || grant_id !== 2'd0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: ready=%b grant=%0d lock=%b, want 0001/0/0", req_ready, grant_id, lock);
    end
    set_req(0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || tx_wr_en !== 1'b1 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_issue: ready=%b wr_en=%b data=%h, want 0000/1/a5", req_ready, tx_wr_en, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_wr_en !== 1'b0 || tx_data !== 8'hA5 || lock !== 1'b0) begin
      errors++;
      $display("FAIL single_strobe_end: wr_en=%b data=%h lock=%b, want 0/a5/0", tx_wr_en, tx_data, lock);
    end
    wait_idle();
    checks++;
    if (rx_byte !== 8'hA5 || grant_id !== 2'd0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL single_loopback: rx=%h grant=%0d lock=%b, want a5/0/0", rx_byte, grant_id, lock);
    end
  endtask

  task automatic test_contend();
    logic [7:0] exp_b [4];
    int k; bit ok;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) set_req(i, exp_b[i], 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
        wait_ready(60, k, ok);
        checks++;
        if (!ok || k != i) begin
          errors++;
          $display("FAIL contend_order r%0d s%0d: granted %0d, want %0d", r, i, k, i);
        end
        if (ok) set_req(k, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_wr_en !== 1'b1 || tx_data !== exp_b[i]) begin
          errors++;
          $display("FAIL contend_byte r%0d s%0d: wr_en=%b data=%h, want 1/%h", r, i, tx_wr_en, tx_data, exp_b[i]);
        end
      end
      wait_idle();
    end
  endtask

  task automatic test_lock();
    int  ek [4];
    logic [7:0] eb [4];
    logic el [4];
    int k; bit ok;
    ek[0] = 2; ek[1] = 2; ek[2] = 2; ek[3] = 0;
    eb[0] = 8'hCB; eb[1] = 8'hFF; eb[2] = 8'h00; eb[3] = 8'h5A;
    el[0] = 1'b1; el[1] = 1'b1; el[2] = 1'b0; el[3] = 1'b0;
    // Move the round-robin pointer to 2 so requester 2 is searched before 0.
    set_req(1, 8'h77, 1'b1, 1'b1);
    wait_ready(50, k, ok);
    checks++;
    if (!ok || k != 1) begin
      errors++;
      $display("FAIL lock_prelude: granted %0d, want 1", k);
    end
    set_req(1, 8'h00, 1'b0, 1'b0);
    wait_idle();
    set_req(0, 8'h5A, 1'b1, 1'b1);
    set_req(2, 8'hCB, 1'b0, 1'b1);
    for (int s = 0; s < 4; s++) begin
      wait_ready(60, k, ok);
      checks++;
      if (!ok || k != ek[s] || lock !== el[s]) begin
        errors++;
        $display("FAIL lock_seq s%0d: granted %0d lock=%b, want %0d/%b", s, k, lock, ek[s], el[s]);
      end
      case (s)
        0: set_req(2, 8'hFF, 1'b0, 1'b1);
        1: set_req(2, 8'h00, 1'b1, 1'b1);
        2: set_req(2, 8'h00, 1'b0, 1'b0);
        default: set_req(0, 8'h00, 1'b0, 1'b0);
      endcase
      @(negedge clk);
      checks++;
      if (tx_wr_en !== 1'b1 || tx_data !== eb[s]) begin
        errors++;
        $display("FAIL lock_byte s%0d: wr_en=%b data=%h, want 1/%h", s, tx_wr_en, tx_data, eb[s]);
      end
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int k, n; bit ok, seen;
    model_en = 1'b0;
    set_req(3, 8'h3C, 1'b0, 1'b1);
    wait_ready(50, k, ok);
    checks++;
    if (!ok || k != 3 || lock !== 1'b1) begin
      errors++;
      $display("FAIL timeout_accept: granted %0d lock=%b, want 3/1", k, lock);
    end
    set_req(3, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'h3C) begin
      errors++;
      $display("FAIL timeout_issue: wr_en=%b data=%h, want 1/3c", tx_wr_en, tx_data);
    end
    n = 0; seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (timeout_err) seen = 1'b1;
    end
    checks++;
    if (!seen || n != BUSY_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_delay: err after %0d cycles (seen=%b), want %0d", n, seen, BUSY_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0 || lock !== 1'b0) begin
      errors++;
      $display("FAIL timeout_after: err=%b lock=%b, want 0/0", timeout_err, lock);
    end
    model_en = 1'b1;
    set_req(0, 8'h5E, 1'b1, 1'b1);
    wait_ready(50, k, ok);
    set_req(0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (!ok || k != 0 || tx_wr_en !== 1'b1 || tx_data !== 8'h5E) begin
      errors++;
      $display("FAIL timeout_recover: granted %0d wr_en=%b data=%h, want 0/1/5e", k, tx_wr_en, tx_data);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int k, n; bit ok, hi;
    set_req(1, 8'h81, 1'b0, 1'b1);
    wait_ready(50, k, ok);
    set_req(1, 8'h00, 1'b0, 1'b0);
    hi = 1'b0;
    for (n = 0; n < 20 && !hi; n++) begin
      @(negedge clk);
      if (tx_busy) hi = 1'b1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || k != 1 || !hi || lock !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL midreset_pre: granted %0d busy=%b lock=%b grant=%0d, want 1/1/1/1", k, hi, lock, grant_id);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || tx_data !== 8'h00 || tx_wr_en !== 1'b0 ||
        grant_id !== 2'd0 || lock !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: ready=%b data=%h wr=%b grant=%0d lock=%b to=%b, want all 0",
               req_ready, tx_data, tx_wr_en, grant_id, lock, timeout_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2, 8'h92, 1'b1, 1'b1);
    wait_ready(60, k, ok);
    checks++;
    if (!ok || k != 2 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_accept: granted %0d busy=%b, want 2/0", k, tx_busy);
    end
    set_req(2, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'h92) begin
      errors++;
      $display("FAIL midreset_issue: wr_en=%b data=%h, want 1/92", tx_wr_en, tx_data);
    end
    wait_idle();
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL midreset_overlap: strobe during busy=%b, want 0", overlap);
    end
  endtask

  task automatic test_busy_held();
    int bad;
    ext_busy = 1'b1;
    set_req(0, 8'h0F, 1'b1, 1'b1);
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_hold: ready seen in %0d cycles while busy, want 0", bad);
    end
    ext_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL busy_release: ready=%b, want 0001", req_ready);
    end
    set_req(0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'h0F) begin
      errors++;
      $display("FAIL busy_issue: wr_en=%b data=%h, want 1/0f", tx_wr_en, tx_data);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_busy_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
